// File: rtl/qupls4_idiv_pkg.sv
// Shared types for the Qupls4 iterative divider: operation encoding and
// controller state.
package qupls4_idiv_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_func_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREP,
      ST_DIV,
      ST_FIX
   } div_state_t;

   function automatic logic is_signed_op(input div_func_t f);
      return (f == DIV) || (f == REM);
   endfunction

   function automatic logic is_rem_op(input div_func_t f);
      return (f == REM) || (f == REMU);
   endfunction

endpackage

// File: rtl/qupls4_idiv_div_step.sv
// One radix-2 restoring divide step: shift {rem,quo} left, trial-subtract the
// divisor, keep the difference when it does not go negative.
module qupls4_div_step #(
   parameter int WID = 64
) (
   input  logic [WID:0]   rem,
   input  logic [WID-1:0] quo,
   input  logic [WID-1:0] divisor,
   output logic [WID:0]   rem_next,
   output logic [WID-1:0] quo_next
);

   logic [WID:0] shifted;
   logic [WID:0] trial;
   logic         fits;

   always_comb begin
      shifted  = {rem[WID-1:0], quo[WID-1]};
      trial    = shifted - {1'b0, divisor};
      // A set rem MSB means the shifted value exceeds any WID-bit divisor.
      fits     = ~trial[WID] | rem[WID];
      rem_next = fits ? trial : shifted;
      quo_next = {quo[WID-2:0], fits};
   end

endmodule

// File: rtl/qupls4_idiv.sv
// Iterative signed/unsigned divide and remainder unit, one quotient bit per
// cycle, with an issue/done handshake matching the lane multiplier.
module qupls4_idiv
   import qupls4_idiv_pkg::*;
#(
   parameter int WID  = 64,
   parameter int LANE = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           issue,
   input  logic [1:0]     func,
   input  logic [WID-1:0] a,
   input  logic [WID-1:0] b,
   output logic [WID-1:0] o,
   output logic           div_done,
   output logic           dbz,
   output logic           busy
);

   localparam int CW = $clog2(WID);

   if (((WID % 16) != 0) || (LANE < 0)) begin : g_param_check
      $error("qupls4_idiv: WID must be a multiple of 16 and LANE non-negative");
   end

   div_state_t     state_reg;
   div_func_t      func_reg;
   logic [WID-1:0] a_reg;
   logic [WID-1:0] b_reg;
   logic [WID-1:0] dvsr_reg;
   logic [WID-1:0] quo_reg;
   logic [WID:0]   rem_reg;
   logic [CW-1:0]  cnt_reg;
   logic           qsign_reg;
   logic           rsign_reg;
   logic           dz_reg;

   logic [WID:0]   rem_next;
   logic [WID-1:0] quo_next;
   logic [WID-1:0] quo_fix;
   logic [WID-1:0] rem_fix;
   logic           sgn_op;

   qupls4_div_step #(.WID(WID)) u_step (
      .rem      (rem_reg),
      .quo      (quo_reg),
      .divisor  (dvsr_reg),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   assign sgn_op  = is_signed_op(func_reg);
   assign quo_fix = qsign_reg ? -quo_reg : quo_reg;
   assign rem_fix = rsign_reg ? -rem_reg[WID-1:0] : rem_reg[WID-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         func_reg  <= DIV;
         a_reg     <= '0;
         b_reg     <= '0;
         dvsr_reg  <= '0;
         quo_reg   <= '0;
         rem_reg   <= '0;
         cnt_reg   <= '0;
         qsign_reg <= 1'b0;
         rsign_reg <= 1'b0;
         dz_reg    <= 1'b0;
         o         <= '0;
         div_done  <= 1'b0;
         dbz       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         div_done <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (issue) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  func_reg  <= div_func_t'(func);
                  busy      <= 1'b1;
                  state_reg <= ST_PREP;
               end
            end
            ST_PREP: begin
               qsign_reg <= sgn_op & (a_reg[WID-1] ^ b_reg[WID-1]);
               rsign_reg <= sgn_op & a_reg[WID-1];
               quo_reg   <= (sgn_op && a_reg[WID-1]) ? -a_reg : a_reg;
               dvsr_reg  <= (sgn_op && b_reg[WID-1]) ? -b_reg : b_reg;
               rem_reg   <= '0;
               dz_reg    <= (b_reg == '0);
               if (b_reg == '0) begin
                  // Divide-by-zero idles one extra cycle in FIX.
                  cnt_reg   <= CW'(1);
                  state_reg <= ST_FIX;
               end else begin
                  cnt_reg   <= CW'(WID - 1);
                  state_reg <= ST_DIV;
               end
            end
            ST_DIV: begin
               rem_reg <= rem_next;
               quo_reg <= quo_next;
               if (cnt_reg == '0)
                  state_reg <= ST_FIX;
               else
                  cnt_reg <= cnt_reg - CW'(1);
            end
            ST_FIX: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - CW'(1);
               end else begin
                  if (dz_reg)
                     o <= is_rem_op(func_reg) ? a_reg : '1;
                  else
                     o <= is_rem_op(func_reg) ? rem_fix : quo_fix;
                  dbz       <= dz_reg;
                  div_done  <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule
